fifo_rd_packer: RTL
===================

# fifo_rd_packer

Read-side stage placed directly downstream of `fifo_gray`. It pops `DATA_WIDTH`-bit entries from the FIFO, packs `PACK_RATIO` consecutive entries into one wide word, and presents that word on a valid/ready stream through a 2-entry output buffer. It sustains one FIFO pop per cycle while the consumer keeps `out_ready` high.

## Interface
- `DATA_WIDTH`, 8, width of one FIFO entry.
- `PACK_RATIO`, 4, entries per output word; must be ≥2.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `fifo_pop` out 1: pop request to the FIFO.
- `fifo_data` in `DATA_WIDTH`: FIFO read data. It is valid in the cycle after a pop, because the FIFO has 1-cycle read latency.
- `fifo_empty` in 1: FIFO empty flag.
- `out_valid` out 1: the output word is valid.
- `out_ready` in 1: the consumer accepts the word.
- `out_data` out `DATA_WIDTH*PACK_RATIO`: packed word.
- `busy` out 1: high while any lane is assembled, a pop is in flight, or the output buffer is non-empty.
- `flush` in 1: single-cycle flush request. Present only with `FIFO_PACK_FLUSH_EN`.
- `flush_done` out 1: single-cycle pulse when a flush completes. Present only with `FIFO_PACK_FLUSH_EN`.
- `out_keep` out `PACK_RATIO`: per-lane valid mask. Present only with `FIFO_PACK_FLUSH_EN`.

## Operation
- Internal state:
  - Lane counter `cnt` (0..`PACK_RATIO`-1).
  - In-flight flag `infl`, set the cycle after `fifo_pop`.
  - Assembly register.
  - Output buffer with `out_cnt` 0..2.
- Lane order: the first byte of a word lands in lane 0 (`out_data[DATA_WIDTH-1:0]`), and later bytes go to ascending lanes.
- `fifo_pop` = `!fifo_empty && (out_cnt < 2 || cnt + infl < PACK_RATIO-1) && !flushing`.
  - The byte that completes a word is popped only when a buffer slot is guaranteed.
  - `out_cnt` rises only on word completion, so that slot is still free when the byte arrives.
- When a byte arrives (`infl`):
  - It is written to lane `cnt`, and `cnt` increments.
  - On reaching `PACK_RATIO`, the full word is pushed into the output buffer on the same edge and `cnt` returns to 0.
- Output buffer:
  - FIFO-ordered.
  - A word is presented while `out_cnt > 0`.
  - A word is retired on `out_valid && out_ready`.
  - A push and a pop in the same cycle leave `out_cnt` unchanged.
- `out_data` is held stable while `out_valid && !out_ready`.
- The block never pops while `fifo_empty` is high.
- Reset mid-operation discards assembled lanes, the in-flight byte, and buffered words.
- Reset values:
  - `fifo_pop` = 0, `out_valid` = 0, `out_data` = 0, `busy` = 0.
  - `flush_done` = 0, `out_keep` = 0.

## Timing
- Pop to lane write: 1 cycle.
- Final-lane pop to `out_valid`: 2 cycles, i.e. `out_valid` is high in the cycle after data arrival.
- Throughput: 1 entry/cycle and 1 word per `PACK_RATIO` cycles while `out_ready` = 1 and the FIFO is non-empty.
- With `out_ready` held low:
  - Pops stop once `out_cnt` = 2 and `cnt + infl` = `PACK_RATIO`-1.
  - At most `2*PACK_RATIO + PACK_RATIO-1` entries are absorbed.
- Consumer stall recovery: popping resumes in the cycle after the retiring handshake.

## Configuration
- `FIFO_PACK_FLUSH_EN` defined: adds `flush`, `flush_done` and `out_keep`, plus this FSM:
  - **RUN**: normal operation. On `flush`, go to DRAIN.
  - **DRAIN**: no pops. Wait until `infl` = 0.
    - If `cnt > 0`, go to EMIT.
    - If `cnt` = 0, go to DONE.
  - **EMIT**: wait for `out_cnt < 2`, then push the partial word.
    - Unused lanes are 0.
    - `out_keep` = `(1<<cnt)-1`.
    - Clear `cnt` and go to DONE.
  - **DONE**: pulse `flush_done` for 1 cycle and return to RUN.
  - Full words carry `out_keep` = all ones.
  - `flush` asserted outside RUN is ignored.
- `FIFO_PACK_FLUSH_EN` undefined:
  - The ports and FSM do not exist.
  - Only full words are emitted.
  - Partial lanes wait indefinitely for further FIFO data.

## Test plan
- Full words: FIFO holds 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 and `out_ready` = 1 → words 0x44332211 then 0x88776655. `fifo_pop` is high for 8 consecutive cycles.
- Backpressure: 16 entries 0x00..0x0F, `out_ready` = 0 →
  - `out_cnt` reaches 2 and pops stop after 11 entries.
  - `out_data` stays 0x03020100.
  - Releasing `out_ready` yields 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C in order with no loss.
- Empty FIFO: `fifo_empty` = 1 for 20 cycles → `fifo_pop` stays 0, `out_valid` stays 0 and `busy` stays 0.
- Async reset: assert `rst_n` = 0 with 2 lanes assembled and 1 word buffered → all outputs drop to 0 immediately. After release, the next 4 entries 0xA1..0xA4 produce 0xA4A3A2A1.
- Flush (`FIFO_PACK_FLUSH_EN`): 3 entries 0xC1,0xC2,0xC3 then `flush` →
  - Word 0x00C3C2C1 is emitted with `out_keep` = 4'b0111.
  - `flush_done` pulses once.
  - A flush with `cnt` = 0 gives `flush_done` and no word.
- Concurrent push/pop of the buffer: `out_ready` toggles 1,0,1,0 during a continuous stream → no duplicated or dropped words, and `out_cnt` never exceeds 2.

Source files
------------

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_rd_packer                                                           |
// | Pops entries from a 1-cycle-latency FIFO, packs PACK_RATIO of them into  |
// | one word and streams it out through a 2-entry valid/ready buffer.        |
// | Optional flush support: define FIFO_PACK_FLUSH_EN.                       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             fifo_pop,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  input  logic                             fifo_empty,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic                             busy
`ifdef FIFO_PACK_FLUSH_EN
  ,
  input  logic                             flush,
  output logic                             flush_done,
  output logic [PACK_RATIO-1:0]            out_keep
`endif
);

  localparam int c_cw = $clog2(PACK_RATIO + 1);
  localparam int c_ww = DATA_WIDTH * PACK_RATIO;
  localparam logic [c_cw-1:0] c_last = c_cw'(PACK_RATIO - 1);

  logic              r_armed;
  logic              r_infl;
  logic [c_cw-1:0]   r_cnt;
  logic [c_ww-1:0]   r_asm;
  logic [1:0]        r_out_cnt;
  logic [c_ww-1:0]   r_buf0;
  logic [c_ww-1:0]   r_buf1;

  logic              w_flushing;
  logic              w_push_full;
  logic              w_push_part;
  logic              w_push;
  logic              w_retire;
  logic [c_cw:0]     w_fill;
  logic [c_ww-1:0]   w_full_word;
  logic [c_ww-1:0]   w_push_data;
  logic              w_ld0;
  logic              w_ld1;
  logic              w_sh;
  logic [1:0]        w_out_cnt_nxt;

  assign w_fill      = {1'b0, r_cnt} + {{c_cw{1'b0}}, r_infl};
  // The word-completing byte is only requested when a buffer slot is certain.
  assign fifo_pop    = r_armed && !fifo_empty && !w_flushing &&
                       ((r_out_cnt != 2'd2) || (w_fill < {1'b0, c_last}));
  assign w_push_full = r_infl && (r_cnt == c_last);
  assign w_push      = w_push_full || w_push_part;
  assign out_valid   = (r_out_cnt != 2'd0);
  assign w_retire    = out_valid && out_ready;
  assign out_data    = r_buf0;
  assign busy        = (r_cnt != '0) || r_infl || (r_out_cnt != 2'd0);

  always_comb begin
    w_full_word = r_asm;
    w_full_word[c_ww-1 -: DATA_WIDTH] = fifo_data;
  end

  assign w_ld0 = w_push && ((r_out_cnt == 2'd0) || ((r_out_cnt == 2'd1) && w_retire));
  assign w_ld1 = w_push && (((r_out_cnt == 2'd1) && !w_retire) ||
                            ((r_out_cnt == 2'd2) && w_retire));
  assign w_sh  = w_retire && (r_out_cnt == 2'd2);

  always_comb begin
    w_out_cnt_nxt = r_out_cnt;
    if (w_push && !w_retire)
      w_out_cnt_nxt = r_out_cnt + 2'd1;
    else if (!w_push && w_retire)
      w_out_cnt_nxt = r_out_cnt - 2'd1;
  end

`ifdef FIFO_PACK_FLUSH_EN
  localparam logic [1:0] c_st_run   = 2'd0;
  localparam logic [1:0] c_st_drain = 2'd1;
  localparam logic [1:0] c_st_emit  = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  logic [1:0]            r_state;
  logic [PACK_RATIO-1:0] r_keep0;
  logic [PACK_RATIO-1:0] r_keep1;
  logic [PACK_RATIO-1:0] w_part_keep;
  logic [PACK_RATIO-1:0] w_push_keep;

  assign w_flushing  = (r_state != c_st_run);
  assign w_push_part = (r_state == c_st_emit) && (r_out_cnt != 2'd2);
  // Unused lanes of a partial word are already zero: the assembly register clears on every push.
  assign w_push_data = w_push_part ? r_asm : w_full_word;
  assign w_push_keep = w_push_part ? w_part_keep : {PACK_RATIO{1'b1}};
  assign flush_done  = (r_state == c_st_done);
  assign out_keep    = r_keep0;

  always_comb begin
    w_part_keep = '0;
    for (int i = 0; i < PACK_RATIO; i++)
      w_part_keep[i] = (c_cw'(i) < r_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_run;
      r_keep0 <= '0;
      r_keep1 <= '0;
    end else begin
      case (r_state)
        c_st_run:   if (flush) r_state <= c_st_drain;
        c_st_drain: if (!r_infl) r_state <= (r_cnt != '0) ? c_st_emit : c_st_done;
        c_st_emit:  if (r_out_cnt != 2'd2) r_state <= c_st_done;
        default:    r_state <= c_st_run;
      endcase
      if (w_ld0)
        r_keep0 <= w_push_keep;
      else if (w_sh)
        r_keep0 <= r_keep1;
      if (w_ld1)
        r_keep1 <= w_push_keep;
    end
  end
`else
  assign w_flushing  = 1'b0;
  assign w_push_part = 1'b0;
  assign w_push_data = w_full_word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed   <= 1'b0;
      r_infl    <= 1'b0;
      r_cnt     <= '0;
      r_asm     <= '0;
      r_out_cnt <= 2'd0;
      r_buf0    <= '0;
      r_buf1    <= '0;
    end else begin
      r_armed   <= 1'b1;
      r_infl    <= fifo_pop;
      r_out_cnt <= w_out_cnt_nxt;
      if (w_push_part)
        r_cnt <= '0;
      else if (r_infl)
        r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_cw'(1);
      if (w_push)
        r_asm <= '0;
      else if (r_infl) begin
        for (int i = 0; i < PACK_RATIO; i++)
          if (r_cnt == c_cw'(i))
            r_asm[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
      end
      if (w_ld0)
        r_buf0 <= w_push_data;
      else if (w_sh)
        r_buf0 <= r_buf1;
      if (w_ld1)
        r_buf1 <= w_push_data;
    end
  end

endmodule
`default_nettype wire
